// File: rtl/sccb_target_pkg.sv
// Shared types and constants for the SCCB target.
// Imported by the interface users and the top-level FSM.
package sccb_target_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h21;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/sccb_target_if.sv
// Bus-side and register-side signals of the SCCB target.
// slave = target view, master = bus host / register map view.
interface sccb_target_if;

  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic [7:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_we;
  logic [7:0] i_reg_rdata;
  logic       o_busy;
  logic       o_addr_match;

  modport slave (
    input  i_scl, i_sda, i_reg_rdata,
    output o_sda_oe, o_reg_addr, o_reg_wdata,
    output o_reg_we, o_busy, o_addr_match
  );

  modport master (
    output i_scl, i_sda, i_reg_rdata,
    input  o_sda_oe, o_reg_addr, o_reg_wdata,
    input  o_reg_we, o_busy, o_addr_match
  );

endinterface

// File: rtl/bus_sync_edge.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// Flops reset to 1 so an idle bus produces no spurious events.
module bus_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [STAGES-1:0] scl_ff;
  logic [STAGES-1:0] sda_ff;
  logic              scl_q;
  logic              sda_q;
  logic              scl_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[STAGES-2:0], scl};
      sda_ff <= {sda_ff[STAGES-2:0], sda};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s    = scl_ff[STAGES-1];
  assign sda_s    = sda_ff[STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = ~sda_s & sda_q & scl_s;
  assign stop     = sda_s & ~sda_q & scl_s;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target: 7-bit device address, 8-bit sub-address,
// write and read transfers with open-drain SDA pull-low.
module sccb_target
  import sccb_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
  parameter int         SYNC_STAGES = 2,
  parameter bit         AUTO_INC    = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst,
  sccb_target_if.slave bus
);

  state_e     state;
  logic [7:0] sh;
  logic [7:0] sh_nxt;
  logic [7:0] reg_addr;
  logic [7:0] addr_inc;
  logic [7:0] reg_wdata;
  logic [3:0] cnt;
  logic       rw;
  logic       sda_oe;
  logic       reg_we;
  logic       busy;
  logic       addr_match;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  bus_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .scl      (bus.i_scl),
    .sda      (bus.i_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sh_nxt   = {sh[6:0], sda_s};
  assign addr_inc = reg_addr + {7'd0, AUTO_INC};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      sh         <= 8'h00;
      cnt        <= 4'd0;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      reg_we     <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
    end else begin
      reg_we     <= 1'b0;
      addr_match <= 1'b0;
      if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        cnt    <= 4'd0;
      end else if (start) begin
        state <= ST_ADDR;
        cnt   <= 4'd0;
      end else begin
        unique case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              sh  <= sh_nxt;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (sh_nxt[7:1] == DEV_ADDR) begin
                  addr_match <= 1'b1;
                  busy       <= 1'b1;
                  rw         <= sh_nxt[0];
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= ST_ADDR_ACK;
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 4'd0;
              if (rw) begin
                sh     <= bus.i_reg_rdata;
                sda_oe <= ~bus.i_reg_rdata[7];
                state  <= ST_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_SUB;
              end
            end
          end
          ST_SUB: begin
            if (scl_rise) begin
              sh  <= sh_nxt;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) reg_addr <= sh_nxt;
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= ST_SUB_ACK;
            end
          end
          ST_SUB_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              sh  <= sh_nxt;
              cnt <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                reg_wdata <= sh_nxt;
                reg_we    <= 1'b1;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe   <= 1'b0;
              cnt      <= 4'd0;
              reg_addr <= addr_inc;
              state    <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (cnt == 4'd7) begin
                sda_oe <= 1'b0;
                state  <= ST_RDATA_ACK;
              end else begin
                sh     <= {sh[6:0], 1'b0};
                sda_oe <= ~sh[6];
                cnt    <= cnt + 4'd1;
              end
            end
          end
          ST_RDATA_ACK: begin
            // Only a host ACK reaches the falling edge here.
            if (scl_rise) begin
              if (sda_s == NACK) state <= ST_IGNORE;
              else reg_addr <= addr_inc;
            end else if (scl_fall) begin
              sh     <= bus.i_reg_rdata;
              sda_oe <= ~bus.i_reg_rdata[7];
              cnt    <= 4'd0;
              state  <= ST_RDATA;
            end
          end
          ST_IDLE, ST_IGNORE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_sda_oe     = sda_oe;
  assign bus.o_reg_addr   = reg_addr;
  assign bus.o_reg_wdata  = reg_wdata;
  assign bus.o_reg_we     = reg_we;
  assign bus.o_busy       = busy;
  assign bus.o_addr_match = addr_match;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB host, register model,
// write scoreboard and read-data queue.
module tb_sccb_target;

  localparam int Q = 8;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_bus;

  int n_chk = 0;
  int n_fail = 0;
  int we0 = 0;
  int we1 = 0;
  int match0 = 0;
  int match1 = 0;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] mem0 [256];

  sccb_target_if bus0 ();
  sccb_target_if bus1 ();

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~bus0.o_sda_oe & ~bus1.o_sda_oe;
  assign bus0.i_scl = m_scl;
  assign bus0.i_sda = sda_bus;
  assign bus1.i_scl = m_scl;
  assign bus1.i_sda = sda_bus;
  assign bus1.i_reg_rdata = 8'h00;

  sccb_target #(
    .DEV_ADDR    (7'h21),
    .SYNC_STAGES (2),
    .AUTO_INC    (1'b1)
  ) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0.slave)
  );

  sccb_target #(
    .DEV_ADDR    (7'h3C),
    .SYNC_STAGES (3),
    .AUTO_INC    (1'b0)
  ) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered register-map model for the address-0x21 target.
  always @(posedge clk) begin
    if (rst) begin
      mem0[8'h0A] <= 8'h76;
      mem0[8'h0B] <= 8'h3C;
    end else if (bus0.o_reg_we) begin
      mem0[bus0.o_reg_addr] <= bus0.o_reg_wdata;
    end
    bus0.i_reg_rdata <= mem0[bus0.o_reg_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.o_addr_match) match0++;
      if (bus1.o_addr_match) match1++;
      if (bus0.o_reg_we) begin
        we0++;
        if (wq.size() == 0) chk("we0_unexpected", wq.size(), 1);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("we_id", 0, e.id);
          chk("we_addr", bus0.o_reg_addr, e.a);
          chk("we_data", bus0.o_reg_wdata, e.d);
        end
      end
      if (bus1.o_reg_we) begin
        we1++;
        if (wq.size() == 0) chk("we1_unexpected", wq.size(), 1);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("we_id", 1, e.id);
          chk("we_addr", bus1.o_reg_addr, e.a);
          chk("we_data", bus1.o_reg_wdata, e.d);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] v, input logic exp_ack,
                         input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(a);
    chk(tag, a, exp_ack);
  endtask

  task automatic rd_byte(input logic host_ack, input string tag);
    logic [7:0] v;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
    wr_bit(host_ack);
    if (rq.size() == 0) chk({tag, "_noexp"}, rq.size(), 1);
    else chk(tag, v, rq.pop_front());
  endtask

  initial begin
    int m0;
    int w0;
    tick(2);
    chk("rst_oe", bus0.o_sda_oe, 0);
    chk("rst_addr", bus0.o_reg_addr, 8'h00);
    chk("rst_wdata", bus0.o_reg_wdata, 8'h00);
    chk("rst_we", bus0.o_reg_we, 0);
    chk("rst_busy", bus0.o_busy, 0);
    chk("rst_match", bus0.o_addr_match, 0);
    rst = 1'b0;
    tick(4);

    // 1: single register write
    m0 = match0;
    i2c_start();
    wr_byte(8'h42, 1'b0, "t1_ack_addr");
    chk("t1_match", match0, m0 + 1);
    chk("t1_busy", bus0.o_busy, 1);
    wr_byte(8'h12, 1'b0, "t1_ack_sub");
    wq.push_back('{0, 8'h12, 8'h80});
    wr_byte(8'h80, 1'b0, "t1_ack_data");
    i2c_stop();
    tick(4);
    chk("t1_busy_stop", bus0.o_busy, 0);
    chk("t1_we_cnt", we0, 1);

    // 2: set-address write, repeated START, read two bytes
    i2c_start();
    wr_byte(8'h42, 1'b0, "t2_ack_addr");
    wr_byte(8'h0A, 1'b0, "t2_ack_sub");
    i2c_start();
    wr_byte(8'h43, 1'b0, "t2_ack_raddr");
    rq.push_back(8'h76);
    rd_byte(1'b0, "t2_rd0");
    rq.push_back(8'h3C);
    rd_byte(1'b1, "t2_rd1");
    tick(4);
    chk("t2_oe_nack", bus0.o_sda_oe, 0);
    chk("t2_busy_pre", bus0.o_busy, 1);
    i2c_stop();
    tick(4);
    chk("t2_busy_stop", bus0.o_busy, 0);

    // 3: foreign address is ignored until STOP
    m0 = match0;
    w0 = we0;
    i2c_start();
    wr_byte(8'h60, 1'b1, "t3_nack_addr");
    wr_byte(8'h42, 1'b1, "t3_nack_ign");
    i2c_stop();
    tick(4);
    chk("t3_match", match0, m0);
    chk("t3_we", we0, w0);
    chk("t3_busy", bus0.o_busy, 0);

    // 4: auto-increment wrap, then fixed sub-address
    i2c_start();
    wr_byte(8'h42, 1'b0, "t4_ack_addr");
    wr_byte(8'hFF, 1'b0, "t4_ack_sub");
    wq.push_back('{0, 8'hFF, 8'h11});
    wr_byte(8'h11, 1'b0, "t4_ack_d0");
    wq.push_back('{0, 8'h00, 8'h22});
    wr_byte(8'h22, 1'b0, "t4_ack_d1");
    i2c_stop();
    tick(4);
    chk("t4_addr_wrap", bus0.o_reg_addr, 8'h01);
    i2c_start();
    wr_byte(8'h78, 1'b0, "t4_ack_addr1");
    chk("t4_match1", match1, 1);
    wr_byte(8'hFF, 1'b0, "t4_ack_sub1");
    wq.push_back('{1, 8'hFF, 8'h11});
    wr_byte(8'h11, 1'b0, "t4_ack_d0_1");
    wq.push_back('{1, 8'hFF, 8'h22});
    wr_byte(8'h22, 1'b0, "t4_ack_d1_1");
    i2c_stop();
    tick(4);
    chk("t4_we1_cnt", we1, 2);
    chk("t4_addr_fixed", bus1.o_reg_addr, 8'hFF);

    // 5: STOP after four data bits
    w0 = we0;
    i2c_start();
    wr_byte(8'h42, 1'b0, "t5_ack_addr");
    wr_byte(8'h05, 1'b0, "t5_ack_sub");
    for (int i = 0; i < 4; i++) wr_bit(1'b0);
    i2c_stop();
    tick(4);
    chk("t5_we", we0, w0);
    chk("t5_oe", bus0.o_sda_oe, 0);
    chk("t5_busy", bus0.o_busy, 0);
    chk("t5_addr", bus0.o_reg_addr, 8'h05);

    // 6: reset while the target holds an ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(m0 >= 0 ? 8'h42 >> i : 1'b0);
    m_sda = 1'b1;
    tick(Q);
    chk("t6_oe_ack", bus0.o_sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_oe_rst", bus0.o_sda_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    chk("t6_addr_rst", bus0.o_reg_addr, 8'h00);
    i2c_stop();
    tick(4);
    i2c_start();
    wr_byte(8'h42, 1'b0, "t6_ack_addr");
    wr_byte(8'h33, 1'b0, "t6_ack_sub");
    wq.push_back('{0, 8'h33, 8'h5A});
    wr_byte(8'h5A, 1'b0, "t6_ack_data");
    i2c_stop();
    tick(4);

    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
